// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: sample strobe, 4-sample key debounce and time-edit FSM.
// Define KEY_REPEAT_EN to enable auto-repeat of the up/down keys.
module key_scan_ctrl #(
    parameter int TICK_DIV     = 50000,
    parameter int TIMEOUT      = 1000,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    output logic       time_flag,
    output logic [1:0] edit_mode,
    output logic       mode_pulse,
    output logic       inc_pulse,
    output logic       dec_pulse
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    if (TICK_DIV < 2 || TIMEOUT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
    begin : g_bad_param
        $error("key_scan_ctrl: illegal parameter value");
    end

    logic [TW-1:0] tick_cnt;
    logic [3:0]    hist_m, hist_u, hist_d;
    logic [3:0]    nh_m, nh_u, nh_d;
    logic [2:0]    vld_m, vld_u, vld_d;
    logic          prs_m, prs_u, prs_d;
    logic          acc_m, acc_u, acc_d;
    state_t        state, state_nxt;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic          mode_nxt, inc_nxt, dec_nxt;
    logic          rpt_fire, rpt_u, rpt_d;

    assign time_flag = (tick_cnt == TW'(TICK_DIV - 1));
    assign edit_mode = state;

    assign nh_m = {hist_m[2:0], key_mode};
    assign nh_u = {hist_u[2:0], key_up};
    assign nh_d = {hist_d[2:0], key_down};

    // vld tracks which history bits hold real samples rather than reset fill
    assign prs_m = time_flag && vld_m[2] && (nh_m == 4'b1100);
    assign prs_u = time_flag && vld_u[2] && (nh_u == 4'b1100);
    assign prs_d = time_flag && vld_d[2] && (nh_d == 4'b1100);

    assign acc_m = prs_m;
    assign acc_u = prs_u && !prs_m && !prs_d;
    assign acc_d = prs_d && !prs_m && !prs_u;

    always_ff @(posedge clock) begin
        if (!reset) begin
            tick_cnt   <= '0;
            hist_m     <= 4'b1111;
            hist_u     <= 4'b1111;
            hist_d     <= 4'b1111;
            vld_m      <= '0;
            vld_u      <= '0;
            vld_d      <= '0;
            state      <= RUN;
            idle_cnt   <= '0;
            mode_pulse <= 1'b0;
            inc_pulse  <= 1'b0;
            dec_pulse  <= 1'b0;
        end else begin
            tick_cnt <= time_flag ? '0 : tick_cnt + 1'b1;
            if (time_flag) begin
                hist_m <= nh_m;
                hist_u <= nh_u;
                hist_d <= nh_d;
                vld_m  <= {vld_m[1:0], 1'b1};
                vld_u  <= {vld_u[1:0], 1'b1};
                vld_d  <= {vld_d[1:0], 1'b1};
            end
            state      <= state_nxt;
            idle_cnt   <= idle_nxt;
            mode_pulse <= mode_nxt;
            inc_pulse  <= inc_nxt;
            dec_pulse  <= dec_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        mode_nxt  = 1'b0;
        inc_nxt   = 1'b0;
        dec_nxt   = 1'b0;
        if (time_flag) begin
            if (acc_m) begin
                mode_nxt = 1'b1;
                idle_nxt = '0;
                unique case (state)
                    RUN:      state_nxt = SET_HOUR;
                    SET_HOUR: state_nxt = SET_MIN;
                    SET_MIN:  state_nxt = SET_SEC;
                    SET_SEC:  state_nxt = RUN;
                endcase
            end else if (state != RUN) begin
                inc_nxt = acc_u || rpt_u;
                dec_nxt = acc_d || rpt_d;
                if (acc_u || acc_d || rpt_fire) begin
                    idle_nxt = '0;
                end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
                    state_nxt = RUN;
                    idle_nxt  = '0;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                        : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt, rpt_cnt_nxt, cnt_inc, lim;
    logic          rpt_arm, rpt_arm_nxt;
    logic          rpt_dir, rpt_dir_nxt;
    logic          rpt_run, rpt_run_nxt;
    logic          held, all0, rpt_ok;

    // rpt_dir: 0 = up key armed, 1 = down key armed
    always_comb begin
        held     = rpt_dir ? (!key_down && key_up) : (!key_up && key_down);
        all0     = rpt_dir ? (nh_d == 4'b0000) : (nh_u == 4'b0000);
        cnt_inc  = rpt_cnt + 1'b1;
        lim      = rpt_run ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
        rpt_ok   = time_flag && (state != RUN) && !acc_m && !acc_u &&
                   !acc_d && rpt_arm && held;
        rpt_fire = rpt_ok && all0 && (cnt_inc >= lim);
    end

    assign rpt_u = rpt_fire && !rpt_dir;
    assign rpt_d = rpt_fire && rpt_dir;

    always_comb begin
        rpt_cnt_nxt = rpt_cnt;
        rpt_arm_nxt = rpt_arm;
        rpt_dir_nxt = rpt_dir;
        rpt_run_nxt = rpt_run;
        if (time_flag) begin
            if (acc_m || state == RUN || state_nxt != state) begin
                rpt_cnt_nxt = '0;
                rpt_arm_nxt = 1'b0;
                rpt_run_nxt = 1'b0;
            end else if (acc_u || acc_d) begin
                rpt_cnt_nxt = '0;
                rpt_arm_nxt = 1'b1;
                rpt_dir_nxt = acc_d;
                rpt_run_nxt = 1'b0;
            end else if (rpt_fire) begin
                rpt_cnt_nxt = '0;
                rpt_run_nxt = 1'b1;
            end else if (rpt_ok) begin
                if (cnt_inc < lim) begin
                    rpt_cnt_nxt = cnt_inc;
                end
            end else begin
                rpt_cnt_nxt = '0;
                rpt_arm_nxt = 1'b0;
                rpt_run_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rpt_cnt <= '0;
            rpt_arm <= 1'b0;
            rpt_dir <= 1'b0;
            rpt_run <= 1'b0;
        end else begin
            rpt_cnt <= rpt_cnt_nxt;
            rpt_arm <= rpt_arm_nxt;
            rpt_dir <= rpt_dir_nxt;
            rpt_run <= rpt_run_nxt;
        end
    end
`else
    assign rpt_fire = 1'b0;
    assign rpt_u    = 1'b0;
    assign rpt_d    = 1'b0;
`endif

endmodule
